// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Purpose : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the
//           fetch PC and runs a req/ack handshake to a variable-latency
//           instruction memory. Holds at most one returned instruction that
//           decode could not yet accept. Drives the IF/ID pipeline register
//           and obeys stall (if_en/id_en), flush (id_rst) and PC redirects.
// Ports   :
//   clk, rst            clock, synchronous active-high reset
//   if_rst              IF-stage reset from the controller (same effect as rst)
//   if_en, id_en        IF-stage enable / IF-ID register enable (0 = stall)
//   id_rst              IF/ID flush, loads a bubble
//   redirect_valid/pc   one-cycle PC redirect request and word-aligned target
//   imem_req/addr       instruction memory request and registered address
//   imem_ack/rdata      memory response strobe and instruction word
//   inst_id/pc_id       IF/ID instruction word and its address
//   valid_id            IF/ID holds a real instruction
//   fetch_bubble        ID takes a bubble this cycle because nothing was ready
//   bubble_cnt          saturating count of fetch_bubble cycles
// Revision: 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        id_en,
  input  logic        id_rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        fetch_bubble,
  output logic [15:0] bubble_cnt
);

  // FETCH: a request is open at imem_addr.
  // KILL : the open request is wrong-path; its response is dropped.
  // FULL : no request open; one instruction waits in the buffer.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_KILL  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic        reset;
  logic        consume;
  logic        avail;
  logic [31:0] avail_inst;
  logic [31:0] avail_pc;
  logic [31:0] pc_plus4;
  logic        starved;

  assign reset    = rst | if_rst;
  assign consume  = if_en & id_en & ~id_rst;
  assign pc_plus4 = pc_f_q + 32'd4;

  // Fetch FSM next state. The buffer is occupied exactly when in FULL, so
  // leaving FULL is what empties it. redirect_valid is a one-cycle pulse and
  // is honoured ahead of consume in every state so it is never lost.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    addr_d     = addr_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    avail      = 1'b0;
    avail_inst = buf_inst_q;
    avail_pc   = buf_pc_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_f_d = redirect_pc;
            addr_d = redirect_pc;
          end else begin
            avail      = 1'b1;
            avail_inst = imem_rdata;
            avail_pc   = addr_q;
            pc_f_d     = pc_plus4;
            if (consume) begin
              // Launch the next request immediately: zero-bubble streaming.
              addr_d = pc_plus4;
            end else begin
              buf_inst_d = imem_rdata;
              buf_pc_d   = addr_q;
              state_d    = S_FULL;
            end
          end
        end else if (redirect_valid) begin
          // The open request must complete before a new address may be
          // presented, so imem_addr is left alone here.
          pc_f_d  = redirect_pc;
          state_d = S_KILL;
        end
      end

      S_KILL: begin
        if (redirect_valid) begin
          pc_f_d = redirect_pc;
        end
        if (imem_ack) begin
          addr_d  = redirect_valid ? redirect_pc : pc_f_q;
          state_d = S_FETCH;
        end
      end

      S_FULL: begin
        if (redirect_valid) begin
          pc_f_d  = redirect_pc;
          addr_d  = redirect_pc;
          state_d = S_FETCH;
        end else begin
          avail = 1'b1;
          if (consume) begin
            addr_d  = pc_f_q;
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // IF/ID register next state. Every bubble leaves pc_id untouched; only a
  // bubble caused by an empty fetch path (not a stall or flush) is starved.
  always_comb begin
    inst_id_d  = inst_id_q;
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    starved    = 1'b0;

    if (id_rst) begin
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end else if (id_en) begin
      if (!if_en) begin
        inst_id_d  = NOP_INST;
        valid_id_d = 1'b0;
      end else if (avail) begin
        inst_id_d  = avail_inst;
        pc_id_d    = avail_pc;
        valid_id_d = 1'b1;
      end else begin
        inst_id_d  = NOP_INST;
        valid_id_d = 1'b0;
        starved    = 1'b1;
      end
    end
  end

  assign fetch_bubble = starved & ~reset;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_f_q       <= RESET_PC;
      addr_q       <= RESET_PC;
      buf_inst_q   <= 32'h0000_0000;
      buf_pc_q     <= 32'h0000_0000;
      inst_id_q    <= NOP_INST;
      pc_id_q      <= 32'h0000_0000;
      valid_id_q   <= 1'b0;
      bubble_cnt_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      addr_q       <= addr_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_id_q    <= inst_id_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign imem_req   = ((state_q == S_FETCH) || (state_q == S_KILL)) && !reset;
  assign imem_addr  = addr_q;
  assign inst_id    = inst_id_q;
  assign pc_id      = pc_id_q;
  assign valid_id   = valid_id_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Purpose : Directed self-checking bench for if_stage. A small memory model
//           acks a request once it has been open for lat cycles and returns
//           an address-derived word; expected values are hand-derived.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        if_rst;
  logic        if_en;
  logic        id_en;
  logic        id_rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        fetch_bubble;
  logic [15:0] bubble_cnt;

  int n_cmp;
  int n_err;
  int lat;
  int age;
  bit mem_on;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_rst        (if_rst),
    .if_en         (if_en),
    .id_en         (id_en),
    .id_rst        (id_rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .valid_id      (valid_id),
    .fetch_bubble  (fetch_bubble),
    .bubble_cnt    (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: response appears at the negedge once the request has been
  // open for lat cycles (lat = 1 acks in the first cycle).
  always @(negedge clk) begin
    imem_ack   = mem_on && imem_req && (age >= lat - 1);
    imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst || if_rst)             age <= 0;
    else if (imem_req && !imem_ack) age <= age + 1;
    else                           age <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; if_rst = 1'b0; if_en = 1'b1; id_en = 1'b1; id_rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    lat = 1; age = 0; mem_on = 1'b0;

    // ---- 1: reset, then single-cycle streaming ----
    tick();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_inst",  inst_id, 32'h0);
    check("rst_pc",    pc_id, 32'h0);
    check("rst_valid", {31'd0, valid_id}, 32'd0);
    check("rst_bcnt",  {16'd0, bubble_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check("t1_fbub", {31'd0, fetch_bubble}, 32'd1);
    tick();
    check("t1_valid0", {31'd0, valid_id}, 32'd0);
    check("t1_req0",   {31'd0, imem_req}, 32'd1);
    mem_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_valid", {31'd0, valid_id}, 32'd1);
      check("t1_inst",  inst_id, word(32'(4 * k)));
      check("t1_pc",    pc_id, 32'(4 * k));
    end
    check("t1_bcnt", {16'd0, bubble_cnt}, 32'd1);
    check("t1_addr", imem_addr, 32'd32);

    // ---- 2: three-cycle latency, two bubbles per instruction ----
    lat = 3;
    for (int j = 0; j < 3; j++) begin
      for (int b = 0; b < 2; b++) begin
        tick();
        check("t2_bubble", {31'd0, valid_id}, 32'd0);
        check("t2_addr",   imem_addr, 32'(32 + 4 * j));
        check("t2_req",    {31'd0, imem_req}, 32'd1);
      end
      tick();
      check("t2_inst", inst_id, word(32'(32 + 4 * j)));
      check("t2_pc",   pc_id, 32'(32 + 4 * j));
    end
    check("t2_bcnt", {16'd0, bubble_cnt}, 32'd7);

    // ---- 3: ack lands during a full stall ----
    lat = 1; if_en = 1'b0; id_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("t3_req",   {31'd0, imem_req}, 32'd0);
      check("t3_hold",  pc_id, 32'd40);
      check("t3_valid", {31'd0, valid_id}, 32'd1);
    end
    if_en = 1'b1; id_en = 1'b1;
    tick();
    check("t3_inst", inst_id, word(32'd44));
    check("t3_pc",   pc_id, 32'd44);
    check("t3_addr", imem_addr, 32'd48);
    check("t3_req1", {31'd0, imem_req}, 32'd1);
    tick();
    check("t3_next", pc_id, 32'd48);
    check("t3_bcnt", {16'd0, bubble_cnt}, 32'd7);

    // ---- 4: redirect while a request to 0x8 is open ----
    if_rst = 1'b1;
    tick();
    check("t4_rst_addr", imem_addr, 32'h0);
    check("t4_rst_bcnt", {16'd0, bubble_cnt}, 32'd0);
    check("t4_rst_inst", inst_id, 32'h0);
    if_rst = 1'b0;
    tick();
    tick();
    check("t4_pc4", pc_id, 32'h4);
    lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t4_kill_addr", imem_addr, 32'h8);
    check("t4_kill_req",  {31'd0, imem_req}, 32'd1);
    check("t4_kill_v",    {31'd0, valid_id}, 32'd0);
    tick();
    check("t4_kill_addr2", imem_addr, 32'h8);
    tick();
    check("t4_new_addr", imem_addr, 32'h100);
    check("t4_drop",     {31'd0, valid_id}, 32'd0);
    tick();
    check("t4_wait1", {31'd0, valid_id}, 32'd0);
    tick();
    check("t4_wait2", {31'd0, valid_id}, 32'd0);
    tick();
    check("t4_inst",  inst_id, word(32'h100));
    check("t4_pc",    pc_id, 32'h100);
    check("t4_valid", {31'd0, valid_id}, 32'd1);
    check("t4_bcnt",  {16'd0, bubble_cnt}, 32'd5);

    // ---- 5: flush in the ack cycle ----
    lat = 1; id_rst = 1'b1;
    @(negedge clk); #1;
    check("t5_fbub", {31'd0, fetch_bubble}, 32'd0);
    tick();
    check("t5_valid", {31'd0, valid_id}, 32'd0);
    check("t5_inst",  inst_id, 32'h0);
    check("t5_pc",    pc_id, 32'h100);
    check("t5_req",   {31'd0, imem_req}, 32'd0);
    check("t5_bcnt",  {16'd0, bubble_cnt}, 32'd5);
    id_rst = 1'b0;
    tick();
    check("t5_inst2", inst_id, word(32'h104));
    check("t5_pc2",   pc_id, 32'h104);
    check("t5_addr",  imem_addr, 32'h108);

    // ---- 6: saturation, reset mid-request, PC wrap ----
    lat = 200000;
    repeat (65529) tick();
    check("t6_fffe", {16'd0, bubble_cnt}, 32'h0000_FFFE);
    tick();
    check("t6_ffff", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    repeat (3) tick();
    check("t6_sat",  {16'd0, bubble_cnt}, 32'h0000_FFFF);
    check("t6_addr", imem_addr, 32'h108);
    rst = 1'b1; lat = 1;
    tick();
    check("t6_rst_addr",  imem_addr, 32'h0);
    check("t6_rst_req",   {31'd0, imem_req}, 32'd0);
    check("t6_rst_bcnt",  {16'd0, bubble_cnt}, 32'd0);
    check("t6_rst_valid", {31'd0, valid_id}, 32'd0);
    check("t6_rst_pc",    pc_id, 32'h0);
    rst = 1'b0;
    tick();
    check("t6_inst0", inst_id, word(32'h0));
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t6_rd_addr",  imem_addr, 32'hFFFF_FFFC);
    check("t6_rd_valid", {31'd0, valid_id}, 32'd0);
    tick();
    check("t6_wrap_pc",   pc_id, 32'hFFFF_FFFC);
    check("t6_wrap_inst", inst_id, word(32'hFFFF_FFFC));
    check("t6_wrap_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
